// File: rtl/instr_sequencer_pkg.sv
// Shared control-state codes, opcode classes and the instruction class decoder
// used by the sequencer and its decode stage.
package instr_sequencer_pkg;

  typedef enum logic [7:0] {
    STATE_FETCH_PC   = 8'h01,
    STATE_FETCH_INST = 8'h02,
    STATE_ALU_EXEC   = 8'h03,
    STATE_ALU_STORE  = 8'h04,
    STATE_SET_REG    = 8'h05,
    STATE_NEXT       = 8'h06,
    STATE_FETCH_IMM  = 8'h07,
    STATE_REG_MOVE   = 8'h08,
    STATE_HALT       = 8'h0E,
    STATE_FAULT      = 8'h0F
  } state_e;

  typedef enum logic [7:0] {
    OP_NOP = 8'h00,
    OP_ALU = 8'h01,
    OP_LDI = 8'h02,
    OP_MOV = 8'h03,
    OP_HLT = 8'h04,
    OP_ILL = 8'hFF
  } op_class_e;

  localparam logic [7:0] INSTR_NOP = 8'h00;
  localparam logic [7:0] INSTR_HLT = 8'h3F;

  // Only two encodings of the 00 group are defined; everything else there is illegal.
  function automatic op_class_e class_of(input logic [7:0] instr);
    op_class_e cls;
    case (instr[7:6])
      2'b00: begin
        if (instr == INSTR_NOP) begin
          cls = OP_NOP;
        end else if (instr == INSTR_HLT) begin
          cls = OP_HLT;
        end else begin
          cls = OP_ILL;
        end
      end
      2'b01:   cls = OP_ALU;
      2'b10:   cls = OP_LDI;
      2'b11:   cls = OP_MOV;
      default: cls = OP_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/instr_sequencer_decode.sv
// Combinational instruction decode: opcode class plus the ALU-mode and
// destination-register fields straight from the instruction byte.
module instr_decode
  import instr_sequencer_pkg::*;
(
  input  logic [7:0] instr_i,
  output op_class_e  class_o,
  output logic [2:0] alu_mode_o,
  output logic [2:0] sel_o
);

  assign class_o    = class_of(instr_i);
  assign alu_mode_o = instr_i[5:3];
  assign sel_o      = instr_i[2:0];

endmodule

// File: rtl/instr_sequencer.sv
// Control-unit sequencer: steps each instruction through fetch, decode,
// execute and retire, with sticky HALT/FAULT states and a cycle watchdog.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int STATE_W = 8,
  parameter int CYCLE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         instruction,
  output logic [STATE_W-1:0] state,
  output logic [CYCLE_W-1:0] cycle,
  output logic [7:0]         opcode,
  output logic [2:0]         alu_mode,
  output logic [2:0]         sel_in,
  output logic               halted,
  output logic               fault
);

  localparam logic [CYCLE_W-1:0] CYCLE_MAX = {CYCLE_W{1'b1}};

  state_e             state_q, state_d, seq_next_s;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  op_class_e          opcode_q, opcode_d;
  logic [2:0]         alu_mode_q, alu_mode_d;
  logic [2:0]         sel_in_q, sel_in_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;
  logic               sticky_s;

  op_class_e          dec_class_s;
  logic [2:0]         dec_alu_mode_s;
  logic [2:0]         dec_sel_s;

  instr_decode u_decode (
    .instr_i    (instruction),
    .class_o    (dec_class_s),
    .alu_mode_o (dec_alu_mode_s),
    .sel_o      (dec_sel_s)
  );

  assign sticky_s = (state_q == STATE_HALT) || (state_q == STATE_FAULT);

  // Nominal state sequence, before the watchdog override.
  always_comb begin
    seq_next_s = STATE_FAULT;
    case (state_q)
      STATE_FETCH_PC:   seq_next_s = STATE_FETCH_INST;
      STATE_FETCH_INST: begin
        case (dec_class_s)
          OP_ALU:  seq_next_s = STATE_ALU_EXEC;
          OP_LDI:  seq_next_s = STATE_FETCH_IMM;
          OP_MOV:  seq_next_s = STATE_REG_MOVE;
          OP_NOP:  seq_next_s = STATE_NEXT;
          OP_HLT:  seq_next_s = STATE_HALT;
          default: seq_next_s = STATE_FAULT;
        endcase
      end
      STATE_ALU_EXEC:   seq_next_s = STATE_ALU_STORE;
      STATE_ALU_STORE:  seq_next_s = STATE_NEXT;
      STATE_FETCH_IMM:  seq_next_s = STATE_SET_REG;
      STATE_SET_REG:    seq_next_s = STATE_NEXT;
      STATE_REG_MOVE:   seq_next_s = STATE_NEXT;
      STATE_NEXT:       seq_next_s = STATE_FETCH_PC;
      STATE_HALT:       seq_next_s = STATE_HALT;
      STATE_FAULT:      seq_next_s = STATE_FAULT;
      default:          seq_next_s = STATE_FAULT;
    endcase
  end

  // Watchdog, cycle counter and latched instruction fields.
  always_comb begin
    state_d    = seq_next_s;
    cycle_d    = cycle_q;
    opcode_d   = opcode_q;
    alu_mode_d = alu_mode_q;
    sel_in_d   = sel_in_q;

    if (!sticky_s && (cycle_q == CYCLE_MAX)) begin
      state_d = STATE_FAULT;
    end else begin
      state_d = seq_next_s;
    end

    if (sticky_s) begin
      cycle_d = cycle_q;
    end else if (state_d == STATE_FETCH_PC) begin
      cycle_d = '0;
    end else if (cycle_q == CYCLE_MAX) begin
      cycle_d = cycle_q;
    end else begin
      cycle_d = cycle_q + CYCLE_W'(1);
    end

    if (state_q == STATE_FETCH_INST) begin
      opcode_d   = dec_class_s;
      alu_mode_d = dec_alu_mode_s;
      sel_in_d   = dec_sel_s;
    end else begin
      opcode_d   = opcode_q;
      alu_mode_d = alu_mode_q;
      sel_in_d   = sel_in_q;
    end

    halted_d = (state_d == STATE_HALT);
    fault_d  = (state_d == STATE_FAULT);
  end

  // State and output registers; reset overrides every state including HALT/FAULT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= STATE_FETCH_PC;
      cycle_q    <= '0;
      opcode_q   <= OP_NOP;
      alu_mode_q <= 3'd0;
      sel_in_q   <= 3'd0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      opcode_q   <= opcode_d;
      alu_mode_q <= alu_mode_d;
      sel_in_q   <= sel_in_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  assign state    = STATE_W'(state_q);
  assign cycle    = cycle_q;
  assign opcode   = opcode_q;
  assign alu_mode = alu_mode_q;
  assign sel_in   = sel_in_q;
  assign halted   = halted_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: an instruction-level model checked every cycle,
// plus directed walks through each instruction class with literal expectations.
module tb_instr_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] instruction;
  logic [7:0] state_w;
  logic [3:0] cycle_w;
  logic [7:0] opcode_w;
  logic [2:0] alu_mode_w;
  logic [2:0] sel_in_w;
  logic       halted_w;
  logic       fault_w;

  int n_cmp = 0;
  int n_bad = 0;

  instr_sequencer #(.STATE_W(8), .CYCLE_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .state       (state_w),
    .cycle       (cycle_w),
    .opcode      (opcode_w),
    .alu_mode    (alu_mode_w),
    .sel_in      (sel_in_w),
    .halted      (halted_w),
    .fault       (fault_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %02h, expected %02h", nm, $time, act, exp);
    end
  endtask

  // Instruction-level model: position within the instruction's state list.
  int         m_idx   = 0;
  logic [7:0] m_cls   = 8'h00;
  logic [7:0] m_inst  = 8'h00;
  bit         m_valid = 1'b0;

  function automatic logic [7:0] model_class(input logic [7:0] i);
    if (i == 8'h00)      return 8'h00;
    else if (i == 8'h3F) return 8'h04;
    else if (i < 8'h40)  return 8'hFF;
    else if (i < 8'h80)  return 8'h01;
    else if (i < 8'hC0)  return 8'h02;
    else                 return 8'h03;
  endfunction

  function automatic int seq_len(input logic [7:0] cls);
    case (cls)
      8'h01, 8'h02: return 5;
      8'h03:        return 4;
      default:      return 3;
    endcase
  endfunction

  function automatic logic [7:0] seq_state(input logic [7:0] cls, input int idx);
    if (idx == 0) return 8'h01;
    if (idx == 1) return 8'h02;
    case (cls)
      8'h01:   return (idx == 2) ? 8'h03 : (idx == 3) ? 8'h04 : 8'h06;
      8'h02:   return (idx == 2) ? 8'h07 : (idx == 3) ? 8'h05 : 8'h06;
      8'h03:   return (idx == 2) ? 8'h08 : 8'h06;
      8'h04:   return 8'h0E;
      8'hFF:   return 8'h0F;
      default: return 8'h06;
    endcase
  endfunction

  function automatic bit is_sticky(input logic [7:0] cls, input int idx);
    return (idx == 2) && ((cls == 8'h04) || (cls == 8'hFF));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_idx = 0; m_cls = 8'h00; m_inst = 8'h00; m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_idx == 1) begin
        m_inst = instruction;
        m_cls  = model_class(instruction);
        m_idx  = 2;
      end else if (is_sticky(m_cls, m_idx)) begin
        m_idx = m_idx;
      end else if (m_idx == seq_len(m_cls) - 1) begin
        m_idx = 0;
      end else begin
        m_idx = m_idx + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model.state",    state_w,             seq_state(m_cls, m_idx));
      chk("model.cycle",    {4'h0, cycle_w},     8'(m_idx));
      chk("model.opcode",   opcode_w,            m_cls);
      chk("model.alu_mode", {5'd0, alu_mode_w},  {5'd0, m_inst[5:3]});
      chk("model.sel_in",   {5'd0, sel_in_w},    {5'd0, m_inst[2:0]});
      chk("model.halted",   {7'd0, halted_w},    {7'd0, is_sticky(m_cls, m_idx) && m_cls == 8'h04});
      chk("model.fault",    {7'd0, fault_w},     {7'd0, is_sticky(m_cls, m_idx) && m_cls == 8'hFF});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic step(input logic [7:0] st, input logic [3:0] cyc);
    tick();
    chk("lit.state", state_w, st);
    chk("lit.cycle", {4'h0, cycle_w}, {4'h0, cyc});
  endtask

  task automatic chk_reset_vals();
    chk("rst.state",  state_w, 8'h01);
    chk("rst.cycle",  {4'h0, cycle_w}, 8'h00);
    chk("rst.opcode", opcode_w, 8'h00);
    chk("rst.alu",    {5'd0, alu_mode_w}, 8'h00);
    chk("rst.sel",    {5'd0, sel_in_w}, 8'h00);
    chk("rst.halted", {7'd0, halted_w}, 8'h00);
    chk("rst.fault",  {7'd0, fault_w}, 8'h00);
  endtask

  initial begin
    reset = 1'b1;
    instruction = 8'h00;
    tick(); tick();
    chk_reset_vals();
    reset = 1'b0;
    step(8'h01 + 8'h01, 4'd1); step(8'h06, 4'd2); step(8'h01, 4'd0);

    instruction = 8'h4A;
    step(8'h02, 4'd1); step(8'h03, 4'd2);
    chk("alu.opcode", opcode_w, 8'h01);
    chk("alu.mode", {5'd0, alu_mode_w}, 8'h01);
    chk("alu.sel", {5'd0, sel_in_w}, 8'h02);
    step(8'h04, 4'd3); step(8'h06, 4'd4); step(8'h01, 4'd0);

    instruction = 8'h85;
    step(8'h02, 4'd1); step(8'h07, 4'd2);
    chk("ldi.opcode", opcode_w, 8'h02);
    chk("ldi.sel", {5'd0, sel_in_w}, 8'h05);
    instruction = 8'hFF;
    step(8'h05, 4'd3);
    chk("ldi.opcode_hold", opcode_w, 8'h02);
    chk("ldi.sel_hold", {5'd0, sel_in_w}, 8'h05);
    chk("ldi.alu_hold", {5'd0, alu_mode_w}, 8'h00);
    step(8'h06, 4'd4); step(8'h01, 4'd0);

    instruction = 8'hD3;
    step(8'h02, 4'd1); step(8'h08, 4'd2);
    chk("mov.opcode", opcode_w, 8'h03);
    chk("mov.src", {5'd0, alu_mode_w}, 8'h02);
    chk("mov.dst", {5'd0, sel_in_w}, 8'h03);
    step(8'h06, 4'd3); step(8'h01, 4'd0);

    instruction = 8'h3F;
    step(8'h02, 4'd1); step(8'h0E, 4'd2);
    chk("hlt.halted", {7'd0, halted_w}, 8'h01);
    chk("hlt.fault", {7'd0, fault_w}, 8'h00);
    chk("hlt.opcode", opcode_w, 8'h04);
    for (int i = 0; i < 20; i++) step(8'h0E, 4'd2);
    reset = 1'b1;
    tick();
    chk_reset_vals();
    reset = 1'b0;

    instruction = 8'h01;
    step(8'h02, 4'd1); step(8'h0F, 4'd2);
    chk("ill.fault", {7'd0, fault_w}, 8'h01);
    chk("ill.halted", {7'd0, halted_w}, 8'h00);
    chk("ill.opcode", opcode_w, 8'hFF);
    for (int i = 0; i < 5; i++) step(8'h0F, 4'd2);
    reset = 1'b1;
    tick();
    chk_reset_vals();
    reset = 1'b0;

    instruction = 8'h4A;
    step(8'h02, 4'd1); step(8'h03, 4'd2); step(8'h04, 4'd3);
    reset = 1'b1;
    tick();
    chk_reset_vals();
    reset = 1'b0;
    instruction = 8'h00;
    step(8'h02, 4'd1); step(8'h06, 4'd2);
    chk("nop.opcode", opcode_w, 8'h00);
    step(8'h01, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
